mole_hit_judge: RTL and testbench
=================================

Name: mole_hit_judge

Overview:
- Sits directly upstream of the score counter; turns raw hole buttons plus current mole position into clean, single-cycle scoring events.
- Output hit_pulse drives the score counter's accumulate clock input.
- Output level_up drives the score counter's weight-increment input (carry_in).
- Debounces buttons, judges hit/miss against the active mole, and paces difficulty level-ups.

Parameters:
- NUM_HOLES, 4, number of holes/buttons; one-hot mole width.
- DEBOUNCE_CYCLES, 16, consecutive stable samples required before a button level is accepted.
- HITS_PER_LEVEL, 8, hits needed to issue one level_up.
- MAX_LEVEL_UPS, 2, cap on total level_up pulses. The score counter's 2-bit weight starts at 1 and would wrap past 3.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, synchronous active-low reset.
- btn_raw, input, NUM_HOLES, asynchronous raw buttons, active high.
- mole_onehot, input, NUM_HOLES, current mole position, one-hot; meaningful only when mole_valid=1.
- mole_valid, input, 1, a mole is up.
- hit_pulse, output, 1, one-cycle pulse per judged hit.
- miss_pulse, output, 1, one-cycle pulse per judged miss.
- level_up, output, 1, one-cycle pulse per level advance.
- hit_count, output, $clog2(HITS_PER_LEVEL), hits toward the next level.
- level, output, 2, level_up pulses issued so far, 0..MAX_LEVEL_UPS.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low (rst_n), sampled on rising clk.
- Reset values: hit_pulse=0, miss_pulse=0, level_up=0, hit_count=0, level=0. FSM=IDLE. Synchronizers=0. Debounce counters=0. Debounced levels=0.
- Reset mid-operation clears everything above. No pulse is emitted in the reset cycle or the cycle after.
- Input path, per button:
  - 2-FF synchronizer.
  - Debounce counter. It resets to 0 whenever the synchronized level equals the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the level still differing, the debounced level flips.
  - press_edge = debounced rising edge. Registered, one cycle.
  - Latency from a stable raw press to press_edge: 2 + DEBOUNCE_CYCLES + 1 cycles.
- FSM states:
  - IDLE: mole_valid=0. Any press_edge gives miss_pulse. Moves to ARMED when mole_valid=1.
  - ARMED: on a press_edge:
    - If (press_edge & mole_onehot)!=0, this is a hit: hit_pulse, then LOCKOUT.
    - Else any press_edge is a miss: miss_pulse, stay ARMED.
    - mole_valid=0 returns to IDLE.
  - LOCKOUT: further press_edges are ignored, with no pulses. Returns to IDLE when mole_valid=0. Moves to ARMED when mole_onehot changes while mole_valid=1.
- Simultaneous presses in the same cycle: a hit dominates. At most one hit_pulse or one miss_pulse per cycle, never both.
- Outputs are registered. Pulses occur one cycle after the judging press_edge.
- Level logic:
  - On each hit_pulse, hit_count increments.
  - When it would reach HITS_PER_LEVEL: hit_count goes to 0. If level<MAX_LEVEL_UPS, level_up pulses in the same cycle as hit_pulse and level increments.
  - At the cap, hit_count still wraps but level_up stays 0.
- Minimum spacing between hit_pulses is 2 cycles, so a downstream edge-sensitive consumer sees distinct edges.

Optional Feature:
- Macro: MISS_PENALTY_EN.
- Defined: each miss_pulse also clears hit_count to 0 in the same cycle. level is unaffected.
- Undefined: a miss only pulses miss_pulse; hit_count is unchanged.

Decomposition:
- Shared package mole_pkg:
  - FSM state enum: IDLE, ARMED, LOCKOUT.
  - Default constants: NUM_HOLES, DEBOUNCE_CYCLES, HITS_PER_LEVEL, MAX_LEVEL_UPS.
  - Level width constant: 2.
- One natural sub-module: btn_debounce. It contains the synchronizer, debounce counter and edge detector for one button, with parameter DEBOUNCE_CYCLES. It is instantiated NUM_HOLES times via a generate loop.

Test Plan:
- Bounce rejection: with DEBOUNCE_CYCLES=16, toggle btn_raw[0] every 3 cycles for 40 cycles, then hold 1, mole_valid=0 -> exactly one miss_pulse, 19 cycles after the hold starts, plus one registered cycle.
- Hit and lockout: mole_onehot=0010, mole_valid=1; press btn 1, then press btn 1 again -> one hit_pulse, hit_count=1, second press silent. Change mole to 0100 -> state ARMED.
- Miss and simultaneous press: mole at 0001. Press btn 2 -> miss_pulse. Then press btns 0 and 3 in the same cycle -> one hit_pulse, no miss_pulse.
- Level cap: 24 hits -> level_up coincides with hits 8 and 16, level=2. Hit 24 gives no level_up; hit_count returns to 0.
- Reset mid-operation: after 5 hits, assert rst_n=0 for one cycle -> hit_count=0, level=0, all pulses 0, FSM IDLE.
- MISS_PENALTY_EN: 3 hits, then a miss -> hit_count=0 with the macro defined; 3 without it.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared types and default constants for the whack-a-mole hit judge.
package mole_pkg;

    localparam int unsigned DEF_NUM_HOLES       = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_HITS_PER_LEVEL  = 8;
    localparam int unsigned DEF_MAX_LEVEL_UPS   = 2;
    localparam int unsigned LEVEL_W             = 2;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LOCKOUT
    } state_e;

endpackage

// File: rtl/mole_hit_judge_if.sv
// Button/mole inputs and scoring-event outputs of the hit judge, grouped as one bus.
interface mole_hit_judge_if
    import mole_pkg::*;
#(
    parameter int unsigned NUM_HOLES      = DEF_NUM_HOLES,
    parameter int unsigned HITS_PER_LEVEL = DEF_HITS_PER_LEVEL
);
    localparam int unsigned CNT_W = $clog2(HITS_PER_LEVEL);

    logic [NUM_HOLES-1:0] btn_raw;
    logic [NUM_HOLES-1:0] mole_onehot;
    logic                 mole_valid;
    logic                 hit_pulse;
    logic                 miss_pulse;
    logic                 level_up;
    logic [CNT_W-1:0]     hit_count;
    logic [LEVEL_W-1:0]   level;

    modport master (
        output btn_raw, mole_onehot, mole_valid,
        input  hit_pulse, miss_pulse, level_up, hit_count, level
    );

    modport slave (
        input  btn_raw, mole_onehot, mole_valid,
        output hit_pulse, miss_pulse, level_up, hit_count, level
    );

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-FF synchronizer, stability counter and registered rising-edge detect.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press_edge
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_dly_q;
    logic [CNT_W-1:0] cnt_q;
    logic             edge_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            cnt_q     <= '0;
            edge_q    <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            deb_dly_q <= deb_q;
            edge_q    <= deb_q & ~deb_dly_q;
            if (sync2_q == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                // Level held long enough: accept it.
                deb_q <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_edge = edge_q;

endmodule

// File: rtl/mole_hit_judge.sv
// Hit/miss judge feeding the score counter; MISS_PENALTY_EN makes a miss clear hit_count.
module mole_hit_judge
    import mole_pkg::*;
#(
    parameter int unsigned NUM_HOLES       = DEF_NUM_HOLES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HITS_PER_LEVEL  = DEF_HITS_PER_LEVEL,
    parameter int unsigned MAX_LEVEL_UPS   = DEF_MAX_LEVEL_UPS
) (
    input  logic             clk,
    input  logic             rst_n,
    mole_hit_judge_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(HITS_PER_LEVEL);

    logic [NUM_HOLES-1:0] press_edge;
    logic [NUM_HOLES-1:0] mole_prev_q;
    state_e               state_q, state_d;
    logic                 hit_q, hit_d;
    logic                 miss_q, miss_d;
    logic                 lvl_up_q, lvl_up_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic                 press_any, press_hit;

    for (genvar i = 0; i < NUM_HOLES; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_raw   (bus.btn_raw[i]),
            .press_edge(press_edge[i])
        );
    end

    assign press_any = |press_edge;
    assign press_hit = |(press_edge & bus.mole_onehot);

    always_comb begin
        state_d = state_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                miss_d = press_any;
                if (bus.mole_valid) state_d = ARMED;
            end
            ARMED: begin
                if (!bus.mole_valid) begin
                    // mole_onehot is meaningless here, so any press is a miss.
                    miss_d  = press_any;
                    state_d = IDLE;
                end else if (press_hit) begin
                    hit_d   = 1'b1;
                    state_d = LOCKOUT;
                end else begin
                    miss_d = press_any;
                end
            end
            LOCKOUT: begin
                if (!bus.mole_valid) begin
                    state_d = IDLE;
                end else if (bus.mole_onehot != mole_prev_q) begin
                    state_d = ARMED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        level_d  = level_q;
        lvl_up_d = 1'b0;
        if (hit_d) begin
            if (count_q == CNT_W'(HITS_PER_LEVEL - 1)) begin
                count_d = '0;
                if (level_q < LEVEL_W'(MAX_LEVEL_UPS)) begin
                    lvl_up_d = 1'b1;
                    level_d  = level_q + 1'b1;
                end
            end else begin
                count_d = count_q + 1'b1;
            end
        end
`ifdef MISS_PENALTY_EN
        if (miss_d) count_d = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            lvl_up_q    <= 1'b0;
            count_q     <= '0;
            level_q     <= '0;
            mole_prev_q <= '0;
        end else begin
            state_q     <= state_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            lvl_up_q    <= lvl_up_d;
            count_q     <= count_d;
            level_q     <= level_d;
            mole_prev_q <= bus.mole_onehot;
        end
    end

    assign bus.hit_pulse  = hit_q;
    assign bus.miss_pulse = miss_q;
    assign bus.level_up   = lvl_up_q;
    assign bus.hit_count  = count_q;
    assign bus.level      = level_q;

endmodule

// File: tb/tb_mole_hit_judge.sv
// Directed bench for mole_hit_judge: vector table plus bounce, reset, level-cap and penalty sequences.
module tb_mole_hit_judge;
    import mole_pkg::*;

`ifdef MISS_PENALTY_EN
    localparam bit PENALTY = 1'b1;
`else
    localparam bit PENALTY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   acc_hit, acc_miss, acc_lu, acc_bad;
    logic [3:0] cur_mole;

    mole_hit_judge_if bus ();

    mole_hit_judge dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] mole;
        logic [3:0] btn;
        int         hits;
        int         misses;
        int         lus;
        int         count;
        int         level;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.hit_pulse) acc_hit++;
        if (bus.miss_pulse) acc_miss++;
        if (bus.level_up) acc_lu++;
        if (bus.hit_pulse && bus.miss_pulse) acc_bad++;
        if (bus.level_up && !bus.hit_pulse) acc_bad++;
    endtask

    // Press, hold long enough to debounce, release and let the release settle.
    task automatic press(input logic [3:0] b);
        acc_hit = 0; acc_miss = 0; acc_lu = 0; acc_bad = 0;
        bus.btn_raw = b;
        repeat (30) tick();
        bus.btn_raw = '0;
        repeat (25) tick();
    endtask

    task automatic do_hit();
        cur_mole = (cur_mole == 4'b0001) ? 4'b0010 : 4'b0001;
        bus.mole_onehot = cur_mole;
        press(cur_mole);
    endtask

    task automatic check_step(input string name, input int h, input int m, input int l,
                              input int c, input int lv);
        check({name, " hits"}, acc_hit, h);
        check({name, " misses"}, acc_miss, m);
        check({name, " level_up"}, acc_lu, l);
        check({name, " hit_count"}, int'(bus.hit_count), c);
        check({name, " level"}, int'(bus.level), lv);
        check({name, " pulse overlap"}, acc_bad, 0);
    endtask

    initial begin
        int first_miss;
        int exp_lu, exp_lv;

        tbl[0] = '{mole: 4'b0010, btn: 4'b0010, hits: 1, misses: 0, lus: 0, count: 1, level: 0};
        tbl[1] = '{mole: 4'b0010, btn: 4'b0010, hits: 0, misses: 0, lus: 0, count: 1, level: 0};
        tbl[2] = '{mole: 4'b0100, btn: 4'b0100, hits: 1, misses: 0, lus: 0, count: 2, level: 0};
        tbl[3] = '{mole: 4'b0001, btn: 4'b0100, hits: 0, misses: 1, lus: 0,
                   count: PENALTY ? 0 : 2, level: 0};
        tbl[4] = '{mole: 4'b0001, btn: 4'b1001, hits: 1, misses: 0, lus: 0,
                   count: PENALTY ? 1 : 3, level: 0};

        rst_n           = 1'b0;
        bus.btn_raw     = '0;
        bus.mole_onehot = '0;
        bus.mole_valid  = 1'b0;
        cur_mole        = 4'b0001;
        repeat (3) @(posedge clk);
        #1;
        check("reset hit_pulse", int'(bus.hit_pulse), 0);
        check("reset miss_pulse", int'(bus.miss_pulse), 0);
        check("reset level_up", int'(bus.level_up), 0);
        check("reset hit_count", int'(bus.hit_count), 0);
        check("reset level", int'(bus.level), 0);
        rst_n = 1'b1;

        // Bounce on button 0 with no mole: only the final stable hold counts.
        acc_hit = 0; acc_miss = 0; acc_lu = 0; acc_bad = 0;
        for (int i = 0; i < 14; i++) begin
            bus.btn_raw[0] = ~bus.btn_raw[0];
            repeat (3) tick();
        end
        check("bounce no early pulse", acc_hit + acc_miss, 0);
        bus.btn_raw[0] = 1'b1;
        first_miss = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.miss_pulse && first_miss < 0) first_miss = k;
        end
        check("bounce miss latency", first_miss, 20);
        check("bounce miss count", acc_miss, 1);
        check("bounce hit count", acc_hit, 0);
        bus.btn_raw = '0;
        repeat (30) tick();

        bus.mole_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.mole_onehot = tbl[i].mole;
            press(tbl[i].btn);
            check_step($sformatf("vec%0d", i), tbl[i].hits, tbl[i].misses, tbl[i].lus,
                       tbl[i].count, tbl[i].level);
        end

        // Mid-operation reset after 5 hits.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) do_hit();
        check("pre-reset hit_count", int'(bus.hit_count), 5);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midreset hit_count", int'(bus.hit_count), 0);
        check("midreset level", int'(bus.level), 0);
        check("midreset pulses", int'({bus.hit_pulse, bus.miss_pulse, bus.level_up}), 0);
        check("midreset state", int'(dut.state_q), int'(IDLE));
        @(posedge clk);
        #1;
        check("post-reset pulses", int'({bus.hit_pulse, bus.miss_pulse, bus.level_up}), 0);

        // 24 hits: level_up on hits 8 and 16 only, level saturates at 2.
        for (int i = 1; i <= 24; i++) begin
            do_hit();
            exp_lu = (i == 8 || i == 16) ? 1 : 0;
            exp_lv = (i >= 16) ? 2 : (i >= 8) ? 1 : 0;
            check_step($sformatf("levelcap hit%0d", i), 1, 0, exp_lu, i % 8, exp_lv);
        end

        // Three hits then a miss.
        for (int i = 1; i <= 3; i++) do_hit();
        check("penalty pre hit_count", int'(bus.hit_count), 3);
        cur_mole = (cur_mole == 4'b0001) ? 4'b0010 : 4'b0001;
        bus.mole_onehot = cur_mole;
        press(4'b0100);
        check_step("penalty miss", 0, 1, 0, PENALTY ? 0 : 3, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
